// File: rtl/iteration_frame_writer.sv
// iteration_frame_writer: pulls iteration-count bursts from the Mandelbrot engine,
// buffers them, maps each count to RGB and writes pixels to a linear frame buffer.
//
// Ports:
//   CLK, reset        clock, asynchronous active-high reset
//   ready, data       engine burst-available flag and iteration word
//   send_data         one-cycle burst request to the engine
//   frame_ready       engine level: every pixel of the frame has been emitted
//   clear_frame       one-cycle pulse releasing the engine's frame_ready
//   total_pixels      pixels per frame at the current resolution
//   mem_we/addr/wdata frame-buffer write, held until mem_ack
//   mem_ack           frame buffer accepted the write this cycle
//   pal_we/addr/data  palette RAM write port (used only with PALETTE_RAM_EN)
//   frame_done        one-cycle pulse after the last pixel of a frame is written
//
// Build option: define PALETTE_RAM_EN to replace the fixed colour map with a
// 256x24 palette RAM; MAP then spends one extra cycle on the RAM read.
module iteration_frame_writer #(
    parameter int SET_SIZE   = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_ITER   = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ready,
    input  logic [31:0] data,
    input  logic        frame_ready,
    input  logic [20:0] total_pixels,
    output logic        send_data,
    output logic        clear_frame,
    output logic        mem_we,
    output logic [20:0] mem_addr,
    output logic [23:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_data,
    output logic        frame_done
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WCW = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
    // Highest occupancy that still leaves room for a whole burst.
    localparam logic [AW:0]    FREE_LIMIT = (AW + 1)'(FIFO_DEPTH - SET_SIZE);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(SET_SIZE - 1);

    typedef enum logic {IDLE, RECV} in_state_t;
    typedef enum logic [1:0] {WIDLE, MAP, WREQ} wr_state_t;

    in_state_t      in_state_q, in_state_d;
    wr_state_t      wr_state_q, wr_state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           send_data_q, send_data_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [31:0]    word_q, word_d;
    logic           mem_we_q, mem_we_d;
    logic [20:0]    mem_addr_q, mem_addr_d;
    logic [23:0]    mem_wdata_q, mem_wdata_d;
    logic           frame_done_q, frame_done_d;
    logic           armed_q, armed_d;
    logic           clear_frame_q, clear_frame_d;
    logic           push, pop, empty, in_set, last_pixel;
    logic [31:0]    fifo_mem [FIFO_DEPTH];

`ifdef PALETTE_RAM_EN
    logic [23:0] pal_mem [256];
    logic [23:0] pal_rd_q, pal_rd_d;
    logic        map_phase_q, map_phase_d;
`else
    logic [7:0]  idx;
    logic [23:0] fixed_color;
    logic        unused_pal;
    assign unused_pal  = ^{pal_we, pal_addr, pal_data};
    assign idx         = word_q[7:0];
    assign fixed_color = {idx, idx[3:0], idx[7:4], ~idx};
`endif

    assign empty      = (count_q == '0);
    assign in_set     = (word_q >= 32'(MAX_ITER));
    assign last_pixel = (mem_addr_q == total_pixels - 21'd1);

    // Ingest FSM. The request is registered, so the first RECV cycle is the one in
    // which send_data is visible to the engine; word 0 arrives the cycle after.
    always_comb begin
        in_state_d  = in_state_q;
        word_cnt_d  = word_cnt_q;
        send_data_d = 1'b0;
        push        = 1'b0;
        case (in_state_q)
            IDLE: begin
                if (ready && count_q <= FREE_LIMIT) begin
                    send_data_d = 1'b1;
                    word_cnt_d  = '0;
                    in_state_d  = RECV;
                end
            end
            RECV: begin
                if (!send_data_q) begin
                    push       = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD)
                        in_state_d = IDLE;
                end
            end
            default: in_state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

`ifdef PALETTE_RAM_EN
    always_comb pal_rd_d = pal_mem[word_q[7:0]];
`endif

    // Write FSM: pop, map to colour, then hold the write until acknowledged.
    always_comb begin
        wr_state_d   = wr_state_q;
        word_d       = word_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
`ifdef PALETTE_RAM_EN
        map_phase_d  = 1'b0;
`endif
        case (wr_state_q)
            WIDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    word_d     = fifo_mem[rd_ptr_q];
                    wr_state_d = MAP;
                end
            end
            MAP: begin
`ifdef PALETTE_RAM_EN
                // Phase 0 lets the RAM read of word_q land in pal_rd_q.
                if (!map_phase_q) begin
                    map_phase_d = 1'b1;
                end else begin
                    mem_wdata_d = in_set ? 24'h000000 : pal_rd_q;
                    mem_we_d    = 1'b1;
                    wr_state_d  = WREQ;
                end
`else
                mem_wdata_d = in_set ? 24'h000000 : fixed_color;
                mem_we_d    = 1'b1;
                wr_state_d  = WREQ;
`endif
            end
            WREQ: begin
                if (mem_ack) begin
                    mem_we_d     = 1'b0;
                    frame_done_d = last_pixel;
                    mem_addr_d   = last_pixel ? 21'd0 : mem_addr_q + 21'd1;
                    wr_state_d   = WIDLE;
                end
            end
            default: wr_state_d = WIDLE;
        endcase
    end

    // frame_done arms the release; a frame_ready already high in the frame_done
    // cycle fires the pulse immediately on the following cycle.
    always_comb begin
        clear_frame_d = (armed_q | frame_done_q) & frame_ready;
        armed_d       = (armed_q | frame_done_q) & ~frame_ready;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            in_state_q    <= IDLE;
            wr_state_q    <= WIDLE;
            word_cnt_q    <= '0;
            send_data_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            word_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            frame_done_q  <= 1'b0;
            armed_q       <= 1'b0;
            clear_frame_q <= 1'b0;
`ifdef PALETTE_RAM_EN
            map_phase_q   <= 1'b0;
`endif
        end else begin
            in_state_q    <= in_state_d;
            wr_state_q    <= wr_state_d;
            word_cnt_q    <= word_cnt_d;
            send_data_q   <= send_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            word_q        <= word_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            frame_done_q  <= frame_done_d;
            armed_q       <= armed_d;
            clear_frame_q <= clear_frame_d;
`ifdef PALETTE_RAM_EN
            map_phase_q   <= map_phase_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr_q] <= data;
    end

`ifdef PALETTE_RAM_EN
    always_ff @(posedge CLK) begin
        if (pal_we)
            pal_mem[pal_addr] <= pal_data;
        pal_rd_q <= pal_rd_d;
    end
`endif

    assign send_data   = send_data_q;
    assign clear_frame = clear_frame_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_iteration_frame_writer.sv
// tb_iteration_frame_writer: engine model plus scoreboard for iteration_frame_writer.
module tb_iteration_frame_writer;

    localparam int SET_SIZE   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int MAX_ITER   = 255;
`ifdef PALETTE_RAM_EN
    localparam int SEND_TO_WE = 5;
`else
    localparam int SEND_TO_WE = 4;
`endif

    logic        CLK = 1'b0, reset = 1'b1, ready = 1'b0, frame_ready = 1'b0;
    logic        mem_ack = 1'b0, pal_we = 1'b0;
    logic [31:0] data = '0;
    logic [20:0] total_pixels = 21'd100;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic        send_data, clear_frame, mem_we, frame_done;
    logic [20:0] mem_addr;
    logic [23:0] mem_wdata;

    iteration_frame_writer #(.SET_SIZE(SET_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .MAX_ITER(MAX_ITER)) dut (
        .CLK(CLK), .reset(reset), .ready(ready), .data(data), .frame_ready(frame_ready),
        .total_pixels(total_pixels), .send_data(send_data), .clear_frame(clear_frame),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int          tests = 0, fails = 0, burst_left = 0, cnt;
    logic [23:0] exp_q[$];
    logic [31:0] words_q[$];
    logic [31:0] w_eng;
    logic [20:0] next_addr = '0;
    logic        exp_fd = 1'b0, exp_clr = 1'b0, pend = 1'b0, ok;
    logic [23:0] pal [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel colour as the frame buffer should receive it for an engine word.
    function automatic logic [23:0] color(input logic [31:0] w);
        logic [7:0] i;
        i = w[7:0];
        if (w >= 32'(MAX_ITER)) return 24'h000000;
`ifdef PALETTE_RAM_EN
        return pal[i];
`else
        return {i, 8'((i << 4) | (i >> 4)), 8'd255 - i};
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(250, 260));
            default: return 32'($urandom_range(0, 254));
        endcase
    endfunction

    // Engine: after seeing send_data, presents SET_SIZE words on the following cycles.
    initial forever begin
        @(posedge CLK); #1;
        if (reset) begin
            burst_left = 0;
        end else if (burst_left > 0) begin
            if (words_q.size() != 0) w_eng = words_q.pop_front();
            else w_eng = rand_word();
            data = w_eng;
            exp_q.push_back(color(w_eng));
            check("occupancy_bound", 32'(exp_q.size() <= FIFO_DEPTH + 1), 32'd1);
            burst_left--;
        end else begin
            data = $urandom;
            if (send_data) burst_left = SET_SIZE;
        end
    end

    // Monitor: checks every write against the scoreboard plus frame_done/clear_frame.
    always @(negedge CLK) begin
        if (!reset) begin
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            check("clear_frame", 32'(clear_frame), 32'(exp_clr));
            exp_clr = (pend || exp_fd) && frame_ready;
            pend    = (pend || exp_fd) && !frame_ready;
            exp_fd  = 1'b0;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", mem_addr, mem_wdata);
                end else begin
                    check("mem_wdata", 32'(mem_wdata), 32'(exp_q[0]));
                    check("mem_addr", 32'(mem_addr), 32'(next_addr));
                    if (mem_ack) begin
                        void'(exp_q.pop_front());
                        exp_fd    = (next_addr == total_pixels - 21'd1);
                        next_addr = exp_fd ? 21'd0 : next_addr + 21'd1;
                    end
                end
            end
        end
    end

    task automatic check_zero_outputs(input string name);
        check({name, "_send_data"}, 32'(send_data), 0);
        check({name, "_clear_frame"}, 32'(clear_frame), 0);
        check({name, "_mem_we"}, 32'(mem_we), 0);
        check({name, "_mem_addr"}, 32'(mem_addr), 0);
        check({name, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({name, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        exp_q.delete();
        words_q.delete();
        burst_left = 0;
        next_addr  = '0;
        exp_fd     = 1'b0;
        exp_clr    = 1'b0;
        pend       = 1'b0;
        #1;
        check_zero_outputs(name);
        repeat (2) @(posedge CLK);
        #3 reset = 1'b0;
    endtask

    task automatic wait_send(output logic seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(posedge CLK); #1;
            seen = send_data;
            n++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_send: send_data 0 after 50 cycles, required 1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || burst_left != 0) && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
    endtask

    initial begin
`ifdef PALETTE_RAM_EN
        for (int i = 0; i < 256; i++) begin
            pal[i] = (i == 5) ? 24'hABCDEF : 24'($urandom);
            @(posedge CLK); #1;
            pal_we = 1'b1; pal_addr = 8'(i); pal_data = pal[i];
        end
        @(posedge CLK); #1;
        pal_we = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        // Directed words: plain colour, in-set at and above MAX_ITER, palette index 5.
        mem_ack = 1'b1;
        words_q = '{32'h12, 32'd255, 32'd300, 32'd5};
        ready = 1'b1;
        wait_send(ok);
        ready = 1'b0;
        cnt = 0;
        while (!mem_we && cnt < 50) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check("send_to_we_latency", 32'(cnt), 32'(SEND_TO_WE));
`ifdef PALETTE_RAM_EN
        check("first_pixel", 32'(mem_wdata), 32'(pal[8'h12]));
`else
        check("first_pixel", 32'(mem_wdata), 32'h1221ED);
`endif
        drain();

        // Backpressure: ack held low, ready held high.
        do_reset("reset_bp");
        mem_ack = 1'b0;
        ready = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(posedge CLK); #1;
            if (send_data) cnt++;
        end
        check("bp_bursts", 32'(cnt), 2);
        check("bp_queued", 32'(exp_q.size()), 8);
        ready = 1'b0;
        mem_ack = 1'b1;
        drain();

        // Frame wrap with a 4-pixel frame, then delayed frame_ready.
        do_reset("reset_wrap");
        total_pixels = 21'd4;
        ready = 1'b1;
        wait_send(ok);
        ready = 1'b0;
        cnt = 0;
        while (!frame_done && cnt < 60) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check("wrap_frame_done", 32'(frame_done), 1);
        check("wrap_addr", 32'(mem_addr), 0);
        repeat (3) @(posedge CLK);
        #1 frame_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (clear_frame) cnt++;
        end
        check("clear_pulses", 32'(cnt), 1);
        frame_ready = 1'b0;
        drain();

        // Randomised traffic against the scoreboard.
        do_reset("reset_rand");
        total_pixels = 21'($urandom_range(3, 9));
        repeat (1500) begin
            @(posedge CLK); #1;
            ready       = 1'($urandom_range(0, 1));
            mem_ack     = ($urandom_range(0, 3) != 0);
            frame_ready = ($urandom_range(0, 4) == 0);
        end
        ready = 1'b0;
        mem_ack = 1'b1;
        frame_ready = 1'b0;
        drain();

        // Reset in the middle of a burst.
        ready = 1'b1;
        wait_send(ok);
        ready = 1'b0;
        @(posedge CLK); #2;
        do_reset("reset_recv");

        // Reset while a write is pending.
        mem_ack = 1'b0;
        ready = 1'b1;
        wait_send(ok);
        ready = 1'b0;
        cnt = 0;
        while (!mem_we && cnt < 50) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check("wreq_reached", 32'(mem_we), 1);
        @(posedge CLK); #2;
        do_reset("reset_wreq");
        mem_ack = 1'b1;
        ready = 1'b1;
        wait_send(ok);
        ready = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
